// File: rtl/hazard_mem_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / data-memory controller.
// Includes the register-match helper used by both hazard and forwarding logic.
package hazard_mem_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic       wr_en,
                                     input logic [4:0] wr_reg,
                                     input logic [4:0] src);
    return wr_en && (wr_reg != REG_ZERO) && (wr_reg == src);
  endfunction

endpackage

// File: rtl/hazard_mem_ctrl_forward_unit.sv
// Combinational forwarding selects for the EX ALU operands and the ID branch
// comparator. The M stage result takes priority over the W stage result.
module hazard_mem_ctrl_forward_unit
  import hazard_mem_ctrl_pkg::*;
(
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegM,
  input  logic       RegWriteM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteW,
  output logic [1:0] fwd_ae,
  output logic [1:0] fwd_be,
  output logic       fwd_ad,
  output logic       fwd_bd
);

  always_comb begin
    fwd_ae = FWD_RF;
    if (reg_match(RegWriteM, WriteRegM, RsE)) begin
      fwd_ae = FWD_M;
    end else if (reg_match(RegWriteW, WriteRegW, RsE)) begin
      fwd_ae = FWD_W;
    end

    fwd_be = FWD_RF;
    if (reg_match(RegWriteM, WriteRegM, RtE)) begin
      fwd_be = FWD_M;
    end else if (reg_match(RegWriteW, WriteRegW, RtE)) begin
      fwd_be = FWD_W;
    end

    fwd_ad = reg_match(RegWriteM, WriteRegM, RsD);
    fwd_bd = reg_match(RegWriteM, WriteRegM, RtD);
  end

endmodule

// File: rtl/hazard_mem_ctrl.sv
// Pipeline hazard controller: stall/flush/forward selects plus the data-memory
// req/ready sequencer, a saturating stall-cycle counter and a sticky timeout.
module hazard_mem_ctrl
  import hazard_mem_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic             BranchD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [4:0]       WriteRegM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteW,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushE,
  output logic             BubbleW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output mem_state_e       dbg_state
);

  localparam int              WC_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MAX_WAIT);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mem_state_e       state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       acc, mem_stall, lwstall, brstall, haz_stall;
  logic [1:0] fwd_ae, fwd_be;
  logic       fwd_ad, fwd_bd;

  assign acc = MemtoRegM || MemWriteM;

  assign lwstall = MemtoRegE &&
                   (reg_match(RegWriteE, WriteRegE, RsD) ||
                    reg_match(RegWriteE, WriteRegE, RtD));

  assign brstall = BranchD &&
                   (reg_match(RegWriteE, WriteRegE, RsD) ||
                    reg_match(RegWriteE, WriteRegE, RtD) ||
                    reg_match(MemtoRegM, WriteRegM, RsD) ||
                    reg_match(MemtoRegM, WriteRegM, RtD));

  assign haz_stall = lwstall || brstall;

  hazard_mem_ctrl_forward_unit u_forward_unit (
    .RsD       (RsD),
    .RtD       (RtD),
    .RsE       (RsE),
    .RtE       (RtE),
    .WriteRegM (WriteRegM),
    .RegWriteM (RegWriteM),
    .WriteRegW (WriteRegW),
    .RegWriteW (RegWriteW),
    .fwd_ae    (fwd_ae),
    .fwd_be    (fwd_be),
    .fwd_ad    (fwd_ad),
    .fwd_bd    (fwd_bd)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // wait_cnt holds the index of the current WAIT cycle (1 on the first one).
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (acc && !dmem_ready) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WC_ONE;
        end
      end
      ST_WAIT: begin
        if (dmem_ready) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != WC_MAX) begin
          wait_cnt_d = wait_cnt_q + WC_ONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase
    timeout_d   = timeout_q || ((state_d == ST_WAIT) && (wait_cnt_d == WC_MAX));
    stall_cnt_d = (StallF && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
  end

  // Reset forces the bubble/flush pattern regardless of the live inputs.
  always_comb begin
    mem_stall = (state_q == ST_WAIT) ? !dmem_ready : (acc && !dmem_ready);
    dmem_req  = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushE    = 1'b1;
    BubbleW   = 1'b1;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (reset_n) begin
      dmem_req  = acc || (state_q == ST_WAIT);
      StallF    = mem_stall || haz_stall;
      StallD    = mem_stall || haz_stall;
      StallE    = mem_stall;
      StallM    = mem_stall;
      FlushE    = !mem_stall && haz_stall;
      BubbleW   = mem_stall;
      ForwardAE = fwd_ae;
      ForwardBE = fwd_be;
      ForwardAD = fwd_ad;
      ForwardBD = fwd_bd;
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_hazard_mem_ctrl.sv
// Bench for hazard_mem_ctrl: directed scenarios plus random traffic, checked
// each cycle against a behavioural model of outstanding accesses and hazards.
module tb_hazard_mem_ctrl;
  import hazard_mem_ctrl_pkg::*;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [4:0]       RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic             BranchD, RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, MemWriteM;
  logic             RegWriteW, dmem_ready;
  logic             dmem_req, StallF, StallD, StallE, StallM, FlushE, BubbleW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             ForwardAD, ForwardBD, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  mem_state_e       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: an access is pending if the previous cycle stalled on memory.
  bit m_pending;
  int m_run;
  bit m_timeout;
  int m_stall_cnt;

  hazard_mem_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .BubbleW(BubbleW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(input bit we, input logic [4:0] wr, input logic [4:0] src);
    return we && (wr != 5'd0) && (wr == src);
  endfunction

  function automatic logic [1:0] fwd_model(input logic [4:0] src);
    if (hit(RegWriteM, WriteRegM, src)) return 2'b10;
    if (hit(RegWriteW, WriteRegW, src)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_pending   = 1'b0;
    m_run       = 0;
    m_timeout   = 1'b0;
    m_stall_cnt = 0;
  endtask

  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    BranchD = 0; RegWriteE = 0; MemtoRegE = 0;
    RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
    RegWriteW = 0; dmem_ready = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},   32'(dmem_req), 0);
    check({tag, "_sf"},    32'(StallF), 0);
    check({tag, "_sd"},    32'(StallD), 0);
    check({tag, "_se"},    32'(StallE), 0);
    check({tag, "_sm"},    32'(StallM), 0);
    check({tag, "_fe"},    32'(FlushE), 1);
    check({tag, "_bw"},    32'(BubbleW), 1);
    check({tag, "_fae"},   32'(ForwardAE), 0);
    check({tag, "_fbe"},   32'(ForwardBE), 0);
    check({tag, "_fad"},   32'(ForwardAD), 0);
    check({tag, "_fbd"},   32'(ForwardBD), 0);
    check({tag, "_tmo"},   32'(mem_timeout), 0);
    check({tag, "_cnt"},   32'(stall_cycles), 0);
    check({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  // One cycle: inputs already set, check at the falling edge, advance the model.
  task automatic step(input bit do_chk);
    bit acc, mstall, lw, br, sf;
    acc    = MemtoRegM || MemWriteM;
    mstall = (acc || m_pending) && !dmem_ready;
    lw = MemtoRegE && (hit(RegWriteE, WriteRegE, RsD) || hit(RegWriteE, WriteRegE, RtD));
    br = BranchD && (hit(RegWriteE, WriteRegE, RsD) || hit(RegWriteE, WriteRegE, RtD) ||
                     hit(MemtoRegM, WriteRegM, RsD) || hit(MemtoRegM, WriteRegM, RtD));
    sf = mstall || lw || br;
    @(negedge clock);
    if (do_chk) begin
      check("dmem_req",  32'(dmem_req), 32'(acc || m_pending));
      check("StallF",    32'(StallF), 32'(sf));
      check("StallD",    32'(StallD), 32'(sf));
      check("StallE",    32'(StallE), 32'(mstall));
      check("StallM",    32'(StallM), 32'(mstall));
      check("FlushE",    32'(FlushE), 32'(!mstall && (lw || br)));
      check("BubbleW",   32'(BubbleW), 32'(mstall));
      check("ForwardAE", 32'(ForwardAE), 32'(fwd_model(RsE)));
      check("ForwardBE", 32'(ForwardBE), 32'(fwd_model(RtE)));
      check("ForwardAD", 32'(ForwardAD), 32'(hit(RegWriteM, WriteRegM, RsD)));
      check("ForwardBD", 32'(ForwardBD), 32'(hit(RegWriteM, WriteRegM, RtD)));
      check("timeout",   32'(mem_timeout), 32'(m_timeout));
      check("stall_cnt", 32'(stall_cycles), 32'(m_stall_cnt));
      check("state",     32'(dbg_state), 32'(m_pending));
    end
    m_run     = mstall ? m_run + 1 : 0;
    m_pending = mstall;
    if (mstall && m_run >= MAX_WAIT) m_timeout = 1'b1;
    if (sf && m_stall_cnt < CNT_MAX) m_stall_cnt++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset("por");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Load-use: one stall cycle, then M-forward once the load reaches MEM.
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 2; RsD = 2;
    step(1);
    clear_inputs();
    RegWriteM = 1; WriteRegM = 2; RsE = 2; RsD = 2;
    step(1);

    // Forward priority and $0 suppression.
    clear_inputs();
    RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5; RsE = 5; RtE = 5;
    step(1);
    WriteRegM = 0; RsE = 0; WriteRegW = 0;
    step(1);
    clear_inputs();
    RegWriteW = 1; WriteRegW = 9; RtE = 9; BranchD = 1; RegWriteE = 1; WriteRegE = 4; RtD = 4;
    step(1);

    // Three wait cycles then ready.
    clear_inputs();
    MemtoRegM = 1; RegWriteM = 1; WriteRegM = 7; dmem_ready = 0;
    repeat (3) step(1);
    dmem_ready = 1;
    step(1);
    clear_inputs();
    step(1);

    // Memory stall overrides a concurrent load-use flush.
    MemtoRegM = 1; WriteRegM = 8; dmem_ready = 0;
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 3; RtD = 3;
    repeat (3) step(1);
    dmem_ready = 1;
    step(1);
    clear_inputs();
    step(1);

    // Timeout: 20 not-ready cycles, flag stays after completion.
    MemWriteM = 1; dmem_ready = 0;
    repeat (20) step(1);
    dmem_ready = 1;
    step(1);
    clear_inputs();
    step(1);

    // Asynchronous reset in the middle of a WAIT.
    MemtoRegM = 1; dmem_ready = 0;
    repeat (2) step(1);
    RegWriteM = 1; WriteRegM = 5; RsE = 5; RsD = 5;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("async_rst");
    model_reset();
    @(posedge clock);
    #1;
    check_reset("rst_hold");
    @(negedge clock);
    reset_n = 1'b1;
    clear_inputs();
    @(posedge clock);
    #1;

    // Random traffic over a small register range to provoke collisions.
    repeat (3000) begin
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      BranchD   = 1'($urandom_range(0, 1)); RegWriteE = 1'($urandom_range(0, 1));
      MemtoRegE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
      MemtoRegM = ($urandom_range(0, 2) == 0); MemWriteM = ($urandom_range(0, 4) == 0);
      RegWriteW = 1'($urandom_range(0, 1));
      dmem_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end

    // Counter saturation under a held load-use stall.
    clear_inputs();
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 3; RsD = 3;
    repeat (CNT_MAX + 6) step(0);
    step(1);
    check("stall_sat", 32'(stall_cycles), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
